uart_rx_ctrl: RTL and testbench
===============================

# uart_rx_ctrl

Serial receiver sitting between the board `uart_rx` pin and the CPU's UART peripheral registers. It synchronizes the asynchronous line, detects and validates start bits, and deserializes 8N1 frames (LSB first) at a fixed bit period. It holds the received byte in a data register with a valid flag that the CPU clears via a read-acknowledge strobe, and it reports framing and overrun errors.

## Interface
- `CLKS_PER_BIT`, 10417, clock cycles per bit (100 MHz / 9600 baud); must be ≥ 8.
- `clk`  in  1  system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `uart_rx`  in  1  raw serial line, idle high, asynchronous to `clk`.
- `rd_ack`  in  1  one-cycle CPU strobe: byte consumed.
- `rx_data`  out  8  last successfully received byte.
- `rx_valid`  out  1  unread byte present in `rx_data`.
- `rx_overrun`  out  1  a byte completed while `rx_valid` was already 1.
- `frame_err`  out  1  last frame had stop bit = 0.
- `rx_busy`  out  1  high in any state other than IDLE.

## Operation
- Input path: 2-FF synchronizer on `uart_rx`, both flops reset to 1. All logic uses the synchronized value `rxs`.
- Counters: bit-period counter `cnt` (width `$clog2(CLKS_PER_BIT)`), bit index `idx` (0–7), shift register `sh[7:0]`.
- Let H = `CLKS_PER_BIT/2` (integer division).
- State machine (IDLE, START, DATA, STOP, WAIT_HIGH):
  - IDLE: `rxs`=0 → START, `cnt`=0.
  - START: `cnt` counts to H−1. At that cycle:
    - `rxs`=0 → DATA, `cnt`=0, `idx`=0.
    - `rxs`=1 → IDLE (glitch rejected; no flags change).
  - DATA: at `cnt`=CLKS_PER_BIT−1, sample the bit into `sh[idx]` and reset `cnt`. After `idx`=7 → STOP.
  - STOP: at `cnt`=CLKS_PER_BIT−1, sample the stop bit.
    - Stop bit = 1: `rx_data`←`sh`, `rx_valid`←1, `frame_err`←0, → IDLE.
    - Stop bit = 0: `rx_data` unchanged, `frame_err`←1, → WAIT_HIGH.
  - WAIT_HIGH: stay until `rxs`=1, then → IDLE. A break condition never produces bytes.
- Overrun: on a good stop bit, if `rx_valid`=1 and `rd_ack`=0, set `rx_overrun`=1 and overwrite `rx_data` with the new byte.
- `rd_ack` clears `rx_valid`, `rx_overrun` and `frame_err`.
- Simultaneous `rd_ack` and good-stop completion in the same cycle:
  - the new byte loads;
  - `rx_valid` stays 1;
  - `rx_overrun` stays 0.
- `rd_ack` while `rx_valid`=0 has no effect.

## Timing
- Reset values: `rx_data`=8'h00, `rx_valid`=0, `rx_overrun`=0, `frame_err`=0, `rx_busy`=0; state IDLE; counters 0.
- Reset mid-frame aborts the frame immediately; the partial byte is lost. After release, the receiver waits in IDLE for the next falling edge of `rxs`.
- Let T0 be the cycle in which IDLE sees `rxs`=0, i.e. 2 cycles after the pin edge.
- Sample points relative to T0:
  - start check at T0+H;
  - data bit k at T0+H+(k+1)·CLKS_PER_BIT;
  - stop bit at T0+H+9·CLKS_PER_BIT.
- `rx_valid` is registered high on the cycle after the stop sample.
- `rx_busy` goes high the cycle after T0. It returns low when the state returns to IDLE.
- Back-to-back frames: a new start bit is detectable on the first IDLE cycle after the stop sample. No idle bit time beyond the stop bit is required.
- Flag clear latency: flags are low on the cycle after `rd_ack` is sampled.

## Configuration
- `UART_RX_MAJORITY_EN` defined: each sample point takes a 2-of-3 majority of `rxs` at that point's cycle −1, 0 and +1. This applies to the start check, data bits and stop bit. The counter timing and sample-point cycles are unchanged; the +1 sample is the registered value used one cycle later.
- Not defined: a single sample of `rxs` at the sample-point cycle. No extra registers are instantiated.

## Test plan
- Use `CLKS_PER_BIT`=16 in all scenarios.
- Send 8'h55 (line transitions at exact bit boundaries) → `rx_valid`=1 at T0+8+144+1; `rx_data`=8'h55; `frame_err`=0; `rx_busy` then 0.
- Send 8'hA3 then 8'h0F back-to-back with no `rd_ack` → after the second frame `rx_data`=8'h0F, `rx_valid`=1, `rx_overrun`=1. `rd_ack` pulse → all three flags 0 next cycle.
- 4-cycle low glitch on `uart_rx` in idle → start rejected; `rx_valid`=0, `rx_busy` back to 0 by T0+9; no flag changes.
- Frame 8'hC3 with stop bit forced 0, then line held low 40 cycles → `frame_err`=1, `rx_data` keeps its prior value, state stays WAIT_HIGH until line high. The next 8'h3C frame is received correctly and clears `frame_err`.
- Assert `reset` during data bit 4 of 8'hFF → outputs at reset values immediately. A subsequent 8'h81 frame is received correctly.
- `UART_RX_MAJORITY_EN` build: single-cycle inverted glitch on each data-bit center while sending 8'h5A → `rx_data`=8'h5A. Without the macro, the same stimulus yields 8'hA5.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: 8N1 serial receiver with CPU-side data/valid register and
// framing/overrun error flags.
// Optional build macro: UART_RX_MAJORITY_EN -- 2-of-3 majority vote at each
// sample point (start check, data bits, stop bit).
module uart_rx_ctrl #(
  parameter int unsigned CLKS_PER_BIT = 10417
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rx,
  input  logic       rd_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_overrun,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    idx, idx_nxt;
  logic [7:0]    sh, sh_nxt;
  logic          good_stop, bad_stop;

  logic sync1, rxs;
  logic samp;

  // Two-flop synchronizer; reset to the idle (high) line level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= uart_rx;
      rxs   <= sync1;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic rxs_d1;

  // One-cycle history of the synchronized line for the vote
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rxs_d1 <= 1'b1;
    else       rxs_d1 <= rxs;
  end

  // sync1 already holds the value rxs takes next cycle, so the vote spans
  // cycles -1/0/+1 without shifting the sample-point timing.
  assign samp = (rxs_d1 & rxs) | (rxs_d1 & sync1) | (rxs & sync1);
`else
  assign samp = rxs;
`endif

  // Receiver state, bit-period counter, bit index and shift register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      sh    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      sh    <= sh_nxt;
    end
  end

  // Next-state, counter and sampling decisions
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    sh_nxt    = sh;
    good_stop = 1'b0;
    bad_stop  = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (!rxs) state_nxt = START;
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_nxt = '0;
          idx_nxt = '0;
          state_nxt = samp ? IDLE : DATA;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt     = '0;
          sh_nxt[idx] = samp;
          if (idx == 3'd7) state_nxt = STOP;
          else             idx_nxt   = idx + 3'd1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt = '0;
          if (samp) begin
            good_stop = 1'b1;
            state_nxt = IDLE;
          end else begin
            bad_stop  = 1'b1;
            state_nxt = WAIT_HIGH;
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      WAIT_HIGH: begin
        if (rxs) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // CPU-visible data register and status flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
    end else if (good_stop) begin
      // A read-ack landing with the new byte consumes the old one, so no overrun.
      rx_data   <= sh;
      rx_valid  <= 1'b1;
      frame_err <= 1'b0;
      if (rd_ack)        rx_overrun <= 1'b0;
      else if (rx_valid) rx_overrun <= 1'b1;
    end else begin
      if (rd_ack && rx_valid) begin
        rx_valid   <= 1'b0;
        rx_overrun <= 1'b0;
        frame_err  <= 1'b0;
      end
      if (bad_stop) frame_err <= 1'b1;
    end
  end

  assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed plus randomized frames against a frame-level
// reference model of the receiver's CPU-visible registers.
module tb_uart_rx_ctrl;
  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       uart_rx;
  logic       rd_ack;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_overrun;
  logic       frame_err;
  logic       rx_busy;

  int checks   = 0;
  int failures = 0;

  logic [7:0] m_data;
  logic       m_valid, m_ovr, m_ferr;

  always #5 clk = ~clk;

  uart_rx_ctrl #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .reset      (reset),
    .uart_rx    (uart_rx),
    .rd_ack     (rd_ack),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_overrun (rx_overrun),
    .frame_err  (frame_err),
    .rx_busy    (rx_busy)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_data"},  rx_data,           m_data);
    chk({tag, "_valid"}, {7'd0, rx_valid},   {7'd0, m_valid});
    chk({tag, "_ovr"},   {7'd0, rx_overrun}, {7'd0, m_ovr});
    chk({tag, "_ferr"},  {7'd0, frame_err},  {7'd0, m_ferr});
  endtask

  task automatic model_reset();
    m_data = 8'h00; m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
  endtask

  task automatic model_frame(input logic [7:0] d, input logic stop_ok, input logic ack_same);
    if (stop_ok) begin
      if (m_valid && !ack_same) m_ovr = 1'b1;
      if (ack_same) m_ovr = 1'b0;
      m_data = d; m_valid = 1'b1; m_ferr = 1'b0;
    end else begin
      m_ferr = 1'b1;
    end
  endtask

  // Start bit + 8 data bits; leaves the stop level driven at the start of the stop bit.
  // With glitch set, each data bit is inverted for one cycle at its center.
  task automatic drive_bits(input logic [7:0] d, input logic glitch, input logic stopb);
    uart_rx = 1'b0;
    tick(CPB);
    for (int k = 0; k < 8; k++) begin
      uart_rx = d[k];
      if (glitch) begin
        tick(CPB / 2);
        uart_rx = ~d[k];
        tick(1);
        uart_rx = d[k];
        tick(CPB / 2 - 1);
      end else begin
        tick(CPB);
      end
    end
    uart_rx = stopb;
  endtask

  task automatic send(input logic [7:0] d, input logic stop_ok);
    drive_bits(d, 1'b0, stop_ok);
    tick(CPB);
    uart_rx = 1'b1;
    model_frame(d, stop_ok, 1'b0);
    if (!stop_ok) tick(3);
  endtask

  task automatic ack();
    rd_ack = 1'b1;
    tick(1);
    rd_ack = 1'b0;
    if (m_valid) begin
      m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
    end
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] gexp;
    logic       bad;
    int         gap;

    reset = 1'b1; uart_rx = 1'b1; rd_ack = 1'b0;
    model_reset();
    tick(3);
    chk_model("reset");
    chk("reset_busy", {7'd0, rx_busy}, 8'd0);
    reset = 1'b0;
    tick(2);

    // 8'h55: rx_valid rises exactly one cycle after the stop sample
    drive_bits(8'h55, 1'b0, 1'b1);
    tick(10);
    chk("t55_valid_early", {7'd0, rx_valid}, 8'd0);
    tick(1);
    model_frame(8'h55, 1'b1, 1'b0);
    chk_model("t55");
    tick(5);
    uart_rx = 1'b1;
    chk("t55_busy", {7'd0, rx_busy}, 8'd0);
    ack();
    chk_model("t55_ack");

    // Back-to-back frames without ack -> overrun
    send(8'hA3, 1'b1);
    send(8'h0F, 1'b1);
    chk_model("b2b");
    ack();
    chk_model("b2b_ack");

    // Short low glitch in idle is rejected at the start check
    uart_rx = 1'b0;
    tick(4);
    chk("glitch_busy_hi", {7'd0, rx_busy}, 8'd1);
    uart_rx = 1'b1;
    tick(7);
    chk("glitch_busy_lo", {7'd0, rx_busy}, 8'd0);
    chk_model("glitch");

    // rd_ack coincident with good-stop completion
    send(8'h11, 1'b1);
    drive_bits(8'h22, 1'b0, 1'b1);
    tick(10);
    rd_ack = 1'b1;
    tick(1);
    rd_ack = 1'b0;
    model_frame(8'h22, 1'b1, 1'b1);
    chk_model("ack_coincide");
    tick(5);
    uart_rx = 1'b1;

    // Framing error, line held low (break), then recovery
    drive_bits(8'hC3, 1'b0, 1'b0);
    tick(CPB + 40);
    model_frame(8'hC3, 1'b0, 1'b0);
    chk_model("break");
    chk("break_busy", {7'd0, rx_busy}, 8'd1);
    uart_rx = 1'b1;
    tick(3);
    chk("break_idle", {7'd0, rx_busy}, 8'd0);
    send(8'h3C, 1'b1);
    chk_model("after_break");

    // Reset during data bit 4 of 8'hFF
    uart_rx = 1'b0;
    tick(CPB);
    uart_rx = 1'b1;
    tick(4 * CPB + CPB / 2);
    reset = 1'b1;
    #1;
    model_reset();
    chk_model("midreset");
    chk("midreset_busy", {7'd0, rx_busy}, 8'd0);
    tick(2);
    reset = 1'b0;
    tick(2);
    send(8'h81, 1'b1);
    chk_model("after_reset");

    // Centre-of-bit glitches: voted away only in the majority build
`ifdef UART_RX_MAJORITY_EN
    gexp = 8'h5A;
`else
    gexp = 8'hA5;
`endif
    ack();
    drive_bits(8'h5A, 1'b1, 1'b1);
    tick(CPB);
    uart_rx = 1'b1;
    model_frame(gexp, 1'b1, 1'b0);
    chk_model("center_glitch");

    // Randomized frames, gaps, acks and stop errors
    for (int i = 0; i < 10; i++) begin
      d   = 8'($urandom);
      bad = ($urandom_range(0, 3) == 0);
      gap = $urandom_range(0, 12);
      if (m_valid && ($urandom_range(0, 1) == 1)) ack();
      send(d, !bad);
      tick(gap);
      chk_model($sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
